// File: rtl/csc_lct_to_gem_match.sv
// CSC LCT to GEM cluster matcher: snapshots one LCT request, derives its
// GEM roll/pad window, then scans eight clusters serially for the best match.
module csc_lct_to_gem_match #(
    parameter int           MXCLST  = 8,
    parameter logic [7:0]   MAXPAD  = 8'd191,
    parameter logic [6:0]   MAXWIRE = 7'd47
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  evenchamber,
    input  logic [4:0]            gem_pad_delta,
    input  logic                  gem_roll_delta,
    input  logic                  lct_vpf,
    input  logic [6:0]            lct_keywire,
    input  logic [7:0]            lct_keyhs,
    output logic                  lct_ready,
    input  logic [MXCLST*15-1:0]  clusters,
    output logic                  match_vld,
    output logic                  match_found,
    output logic [2:0]            match_index,
    output logic [2:0]            match_roll,
    output logic [7:0]            match_pad,
    output logic [2:0]            match_size,
    output logic [3:0]            match_count
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] LOOKUP = 2'd1;
    localparam logic [1:0] SCAN   = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    logic [1:0]           state, state_n;
    logic                 ready_r;
    logic [MXCLST*15-1:0] clst_q;
    logic                 even_q, rdelta_q;
    logic [4:0]           pdelta_q;
    logic [6:0]           kwire_q;
    logic [7:0]           khs_q;

    logic                 valid_r;
    logic [2:0]           roll_r;
    logic [7:0]           pad_r;
    logic [8:0]           lo_r, hi_r;

    logic [2:0]           idx;
    logic                 found_s;
    logic [2:0]           best_idx, best_roll, best_size;
    logic [7:0]           best_pad, best_dist;
    logic [3:0]           count_s;

    logic accept;
    assign accept    = (state == IDLE) && lct_vpf && ready_r;
    assign lct_ready = ready_r;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (accept) state_n = LOOKUP;
            LOOKUP:  state_n = SCAN;
            SCAN:    if (idx == 3'd7) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // LCT-derived roll, pad and pad window
    logic       me1a_c, valid_c;
    logic [7:0] raw_c, pad_c;
    logic [6:0] kw_c, kdiv_c;
    logic [2:0] roll_c;
    logic [8:0] pad9_c, dl9_c, sum_c, lo_c, hi_c;

    always_comb begin
        me1a_c  = khs_q >= 8'd128;
        valid_c = khs_q <= 8'd223;
        raw_c   = me1a_c ? {khs_q[6:0], 1'b0} : khs_q + {1'b0, khs_q[7:1]};
        pad_c   = even_q ? raw_c : MAXPAD - raw_c;
        kw_c    = (kwire_q > MAXWIRE) ? MAXWIRE : kwire_q;
        kdiv_c  = kw_c / 7'd6;
        roll_c  = me1a_c ? 3'd7 : ((kdiv_c > 7'd6) ? 3'd6 : kdiv_c[2:0]);
        pad9_c  = {1'b0, pad_c};
        dl9_c   = {4'b0, pdelta_q};
        sum_c   = pad9_c + dl9_c;
        lo_c    = (dl9_c > pad9_c) ? 9'd0 : pad9_c - dl9_c;
        hi_c    = (sum_c > {1'b0, MAXPAD}) ? {1'b0, MAXPAD} : sum_c;
    end

    // Per-cluster evaluation of the current scan index
    logic [6:0]  base_c;
    logic [14:0] cur_c;
    logic        c_vpf, roll_ok, overlap, hit, better;
    logic [2:0]  c_roll, c_size;
    logic [7:0]  c_pad, dist_c;
    logic [3:0]  cr4, rr4;
    logic [8:0]  span_c, span_hi, ctr_c, padr9;

    always_comb begin
        base_c  = 7'(idx) * 7'd15;
        cur_c   = clst_q[base_c +: 15];
        c_vpf   = cur_c[14];
        c_roll  = cur_c[13:11];
        c_pad   = cur_c[10:3];
        c_size  = cur_c[2:0];
        cr4     = {1'b0, c_roll};
        rr4     = {1'b0, roll_r};
        roll_ok = (cr4 == rr4) ||
                  (rdelta_q && ((cr4 + 4'd1 == rr4) || (rr4 + 4'd1 == cr4)));
        span_c  = {1'b0, c_pad} + {6'b0, c_size};
        span_hi = (span_c > {1'b0, MAXPAD}) ? {1'b0, MAXPAD} : span_c;
        overlap = ({1'b0, c_pad} <= hi_r) && (span_hi >= lo_r);
        ctr_c   = {1'b0, c_pad} + {7'b0, c_size[2:1]};
        padr9   = {1'b0, pad_r};
        dist_c  = 8'((ctr_c >= padr9) ? ctr_c - padr9 : padr9 - ctr_c);
        hit     = valid_r && c_vpf && roll_ok && overlap;
        better  = hit && (!found_s || (dist_c < best_dist));
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ready_r     <= 1'b0;
            clst_q      <= '0;
            even_q      <= 1'b0;
            rdelta_q    <= 1'b0;
            pdelta_q    <= '0;
            kwire_q     <= '0;
            khs_q       <= '0;
            valid_r     <= 1'b0;
            roll_r      <= '0;
            pad_r       <= '0;
            lo_r        <= '0;
            hi_r        <= '0;
            idx         <= '0;
            found_s     <= 1'b0;
            best_idx    <= '0;
            best_roll   <= '0;
            best_pad    <= '0;
            best_size   <= '0;
            best_dist   <= '0;
            count_s     <= '0;
            match_vld   <= 1'b0;
            match_found <= 1'b0;
            match_index <= '0;
            match_roll  <= '0;
            match_pad   <= '0;
            match_size  <= '0;
            match_count <= '0;
        end else begin
            state     <= state_n;
            ready_r   <= (state_n == IDLE);
            match_vld <= 1'b0;
            unique case (state)
                IDLE: if (accept) begin
                    clst_q    <= clusters;
                    even_q    <= evenchamber;
                    rdelta_q  <= gem_roll_delta;
                    pdelta_q  <= gem_pad_delta;
                    kwire_q   <= lct_keywire;
                    khs_q     <= lct_keyhs;
                    idx       <= '0;
                    found_s   <= 1'b0;
                    best_idx  <= '0;
                    best_roll <= '0;
                    best_pad  <= '0;
                    best_size <= '0;
                    best_dist <= '0;
                    count_s   <= '0;
                end
                LOOKUP: begin
                    valid_r <= valid_c;
                    roll_r  <= roll_c;
                    pad_r   <= pad_c;
                    lo_r    <= lo_c;
                    hi_r    <= hi_c;
                end
                SCAN: begin
                    idx <= idx + 3'd1;
                    if (hit) count_s <= count_s + 4'd1;
                    if (better) begin
                        found_s   <= 1'b1;
                        best_idx  <= idx;
                        best_roll <= c_roll;
                        best_pad  <= c_pad;
                        best_size <= c_size;
                        best_dist <= dist_c;
                    end
                end
                DONE: begin
                    match_vld   <= 1'b1;
                    match_found <= found_s;
                    match_index <= best_idx;
                    match_roll  <= best_roll;
                    match_pad   <= best_pad;
                    match_size  <= best_size;
                    match_count <= count_s;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_csc_lct_to_gem_match.sv
// Directed bench for csc_lct_to_gem_match: hand-computed match results,
// latency, request spacing, input snapshot and asynchronous reset abort.
module tb_csc_lct_to_gem_match;

    logic         clock = 1'b0;
    logic         reset;
    logic         evenchamber;
    logic [4:0]   gem_pad_delta;
    logic         gem_roll_delta;
    logic         lct_vpf;
    logic [6:0]   lct_keywire;
    logic [7:0]   lct_keyhs;
    logic         lct_ready;
    logic [119:0] clusters;
    logic         match_vld;
    logic         match_found;
    logic [2:0]   match_index;
    logic [2:0]   match_roll;
    logic [7:0]   match_pad;
    logic [2:0]   match_size;
    logic [3:0]   match_count;

    int n_checks = 0;
    int n_fail   = 0;

    csc_lct_to_gem_match dut (
        .clock          (clock),
        .reset          (reset),
        .evenchamber    (evenchamber),
        .gem_pad_delta  (gem_pad_delta),
        .gem_roll_delta (gem_roll_delta),
        .lct_vpf        (lct_vpf),
        .lct_keywire    (lct_keywire),
        .lct_keyhs      (lct_keyhs),
        .lct_ready      (lct_ready),
        .clusters       (clusters),
        .match_vld      (match_vld),
        .match_found    (match_found),
        .match_index    (match_index),
        .match_roll     (match_roll),
        .match_pad      (match_pad),
        .match_size     (match_size),
        .match_count    (match_count)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [14:0] cl(input logic [2:0] roll,
                                       input logic [7:0] pad,
                                       input logic [2:0] size);
        return {1'b1, roll, pad, size};
    endfunction

    task automatic check_res(input string tag, input int f, input int ix,
                             input int r, input int p, input int s,
                             input int c);
        check({tag, ".found"}, 32'(match_found), f);
        check({tag, ".index"}, 32'(match_index), ix);
        check({tag, ".roll"},  32'(match_roll),  r);
        check({tag, ".pad"},   32'(match_pad),   p);
        check({tag, ".size"},  32'(match_size),  s);
        check({tag, ".count"}, 32'(match_count), c);
    endtask

    task automatic drive(input logic ev, input logic [4:0] pd,
                         input logic rd, input logic [6:0] kw,
                         input logic [7:0] hs, input logic [119:0] cv);
        evenchamber    = ev;
        gem_pad_delta  = pd;
        gem_roll_delta = rd;
        lct_keywire    = kw;
        lct_keyhs      = hs;
        clusters       = cv;
    endtask

    task automatic scramble();
        logic [127:0] junk;
        junk = {$urandom, $urandom, $urandom, $urandom};
        drive(~evenchamber, ~gem_pad_delta, ~gem_roll_delta,
              ~lct_keywire, ~lct_keyhs, junk[119:0]);
    endtask

    // One full request: accept at edge N, result checked at N+10
    task automatic run_req(input string tag, input logic ev,
                           input logic [4:0] pd, input logic rd,
                           input logic [6:0] kw, input logic [7:0] hs,
                           input logic [119:0] cv, input int f,
                           input int ix, input int r, input int p,
                           input int s, input int c);
        check({tag, ".ready_pre"}, 32'(lct_ready), 1);
        drive(ev, pd, rd, kw, hs, cv);
        lct_vpf = 1'b1;
        tick();
        lct_vpf = 1'b0;
        check({tag, ".ready_busy"}, 32'(lct_ready), 0);
        scramble();
        for (int k = 1; k <= 9; k++) begin
            tick();
            check({tag, ".vld_early"}, 32'(match_vld), 0);
        end
        tick();
        check({tag, ".vld"}, 32'(match_vld), 1);
        check_res(tag, f, ix, r, p, s, c);
        check({tag, ".ready_back"}, 32'(lct_ready), 1);
        tick();
        check({tag, ".vld_pulse"}, 32'(match_vld), 0);
        check_res({tag, ".hold"}, f, ix, r, p, s, c);
    endtask

    logic [119:0] cv39, cv40, cv41, cv42;

    initial begin
        reset   = 1'b1;
        lct_vpf = 1'b0;
        drive(1'b0, 5'd0, 1'b0, 7'd0, 8'd0, '0);

        cv39 = '0;
        cv39[3*15 +: 15] = cl(3'd2, 8'd58, 3'd1);
        cv39[5*15 +: 15] = cl(3'd2, 8'd62, 3'd0);
        cv40 = '0;
        cv40[0 +: 15]    = cl(3'd2, 8'd128, 3'd7);
        cv41 = '0;
        cv41[7*15 +: 15] = cl(3'd6, 8'd190, 3'd3);
        cv42 = '0;
        cv42[1*15 +: 15] = cl(3'd0, 8'd191, 3'd7);
        cv42[2*15 +: 15] = cl(3'd0, 8'd31, 3'd0);
        cv42[4*15 +: 15] = cl(3'd0, 8'd32, 3'd0);

        #2;
        check("rst.vld", 32'(match_vld), 0);
        check_res("rst", 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("rst.ready", 32'(lct_ready), 1);

        run_req("tie", 1'b1, 5'd4, 1'b0, 7'd13, 8'd40, cv39,
                1, 3, 2, 58, 1, 2);
        run_req("odd", 1'b0, 5'd2, 1'b0, 7'd13, 8'd40, cv40,
                1, 0, 2, 128, 7, 1);
        run_req("even_nm", 1'b1, 5'd2, 1'b0, 7'd13, 8'd40, cv40,
                0, 0, 0, 0, 0, 0);
        run_req("me1a", 1'b1, 5'd0, 1'b1, 7'd47, 8'd223, cv41,
                1, 7, 6, 190, 3, 1);
        run_req("bad_hs", 1'b1, 5'd0, 1'b1, 7'd47, 8'd224, cv41,
                0, 0, 0, 0, 0, 0);
        run_req("me1a_r0", 1'b1, 5'd0, 1'b0, 7'd47, 8'd223, cv41,
                0, 0, 0, 0, 0, 0);
        run_req("edge", 1'b1, 5'd31, 1'b0, 7'd0, 8'd0, cv42,
                1, 2, 0, 31, 0, 1);

        // Back-to-back: vpf held from N+5, inputs changed at N+3
        drive(1'b1, 5'd4, 1'b0, 7'd13, 8'd40, cv39);
        lct_vpf = 1'b1;
        tick();
        lct_vpf = 1'b0;
        tick();
        tick();
        drive(1'b0, 5'd2, 1'b0, 7'd13, 8'd40, cv40);
        tick();
        tick();
        lct_vpf = 1'b1;
        for (int k = 5; k <= 21; k++) begin
            tick();
            if (k == 11) begin
                lct_vpf = 1'b0;
                check("b2b.accept2", 32'(lct_ready), 0);
            end
            if (k >= 5 && k <= 9)
                check("b2b.ready_busy", 32'(lct_ready), 0);
            if (k == 10) begin
                check("b2b.vld1", 32'(match_vld), 1);
                check_res("b2b.first", 1, 3, 2, 58, 1, 2);
            end else if (k == 21) begin
                check("b2b.vld2", 32'(match_vld), 1);
                check_res("b2b.second", 1, 0, 2, 128, 7, 1);
            end else begin
                check("b2b.vld_idle", 32'(match_vld), 0);
            end
        end
        tick();

        // Reset mid-scan at N+6
        drive(1'b1, 5'd4, 1'b0, 7'd13, 8'd40, cv39);
        lct_vpf = 1'b1;
        tick();
        lct_vpf = 1'b0;
        repeat (6) tick();
        reset = 1'b1;
        #1;
        check("abort.vld", 32'(match_vld), 0);
        check_res("abort", 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        reset = 1'b0;
        tick();
        check("abort.ready", 32'(lct_ready), 1);
        for (int k = 0; k < 14; k++) begin
            tick();
            check("abort.no_vld", 32'(match_vld), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
